// File: rtl/dvp_rgb565_capture_if.sv
// DVP camera bus plus the RGB565 pixel stream produced from it.
// The camera side drives the DVP signals; the capture stage drives the pixel stream.
interface dvp_rgb565_capture_if;
    logic        i_cam_vsync;
    logic        i_cam_href;
    logic [7:0]  i_cam_data;
    logic [15:0] o_rgb565;
    logic        o_valid;
    logic        o_sof;
    logic        o_eol;

    modport master (
        output i_cam_vsync, i_cam_href, i_cam_data,
        input  o_rgb565, o_valid, o_sof, o_eol
    );

    modport slave (
        input  i_cam_vsync, i_cam_href, i_cam_data,
        output o_rgb565, o_valid, o_sof, o_eol
    );
endinterface

// File: rtl/dvp_rgb565_capture.sv
// DVP byte-pair capture: skips settling frames, packs RGB565 pixels with SOF/EOL
// markers, counts captured frames and flags line/frame geometry errors.
module dvp_rgb565_capture #(
    parameter int FRAME_SKIP = 10,
    parameter int H_ACT      = 1024,
    parameter int V_ACT      = 768
) (
    input  logic                   clk,
    input  logic                   rst,
    dvp_rgb565_capture_if.slave    bus,
    input  logic                   i_capture_en,
    input  logic                   i_err_clr,
    output logic [15:0]            o_frame_cnt,
    output logic                   o_err_line,
    output logic                   o_err_frame
);
    localparam int PW = $clog2(H_ACT + 1);
    localparam int LW = $clog2(V_ACT + 1);
    localparam int SW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

    localparam logic [PW-1:0] H_MAX  = PW'(H_ACT);
    localparam logic [PW-1:0] H_LAST = PW'(H_ACT - 1);
    localparam logic [LW-1:0] V_MAX  = LW'(V_ACT);
    localparam logic [SW-1:0] S_MAX  = SW'(FRAME_SKIP);

    localparam logic [1:0] ST_SKIP   = 2'd0;
    localparam logic [1:0] ST_GAP    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic          d_vsync_q, d_href_q;
    logic [7:0]    d_data_q;
    logic          pv_vsync_q, pv_href_q;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [PW-1:0] pixel_cnt_q, pixel_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic          px_ovf_q, px_ovf_d;
    logic          ln_ovf_q, ln_ovf_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic          sof_arm_q, sof_arm_d;

    logic [15:0]   rgb_q, rgb_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          err_line_q, err_line_d;
    logic          err_frame_q, err_frame_d;

    logic vs_fall, vs_rise, href_fall, enter_active;

    assign vs_fall   =  pv_vsync_q & ~d_vsync_q;
    assign vs_rise   = ~pv_vsync_q &  d_vsync_q;
    assign href_fall =  pv_href_q  & ~d_href_q;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        pixel_cnt_d  = pixel_cnt_q;
        line_cnt_d   = line_cnt_q;
        px_ovf_d     = px_ovf_q;
        ln_ovf_d     = ln_ovf_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        sof_arm_d    = sof_arm_q;
        rgb_d        = rgb_q;
        valid_d      = 1'b0;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        // Clear is applied first so a same-cycle error below still sets the flag.
        err_line_d   = err_line_q  & ~i_err_clr;
        err_frame_d  = err_frame_q & ~i_err_clr;
        enter_active = 1'b0;

        case (state_q)
            ST_SKIP: begin
                if (vs_fall) begin
                    if (skip_cnt_q == S_MAX) begin
                        if (i_capture_en) begin
                            state_d      = ST_ACTIVE;
                            enter_active = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (vs_fall && i_capture_en) begin
                    state_d      = ST_ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise) begin
                    // A line still open at vsync rise is simply abandoned.
                    if (line_cnt_q != V_MAX || ln_ovf_q)
                        err_frame_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    phase_d     = 1'b0;
                    state_d     = ST_GAP;
                end else if (d_href_q) begin
                    if (!phase_q) begin
                        hi_d    = d_data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (pixel_cnt_q != H_MAX) begin
                            pixel_cnt_d = pixel_cnt_q + 1'b1;
                            if (line_cnt_q != V_MAX && !ln_ovf_q) begin
                                rgb_d     = {hi_q, d_data_q};
                                valid_d   = 1'b1;
                                sof_d     = sof_arm_q;
                                sof_arm_d = 1'b0;
                                eol_d     = (pixel_cnt_q == H_LAST);
                            end
                        end else begin
                            px_ovf_d = 1'b1;
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    if (href_fall) begin
                        if (line_cnt_q != V_MAX)
                            line_cnt_d = line_cnt_q + 1'b1;
                        else
                            ln_ovf_d = 1'b1;
                        if (pixel_cnt_q != H_MAX || phase_q || px_ovf_q)
                            err_line_d = 1'b1;
                        pixel_cnt_d = '0;
                        px_ovf_d    = 1'b0;
                    end
                end
            end
            default: state_d = ST_SKIP;
        endcase

        if (enter_active) begin
            pixel_cnt_d = '0;
            line_cnt_d  = '0;
            px_ovf_d    = 1'b0;
            ln_ovf_d    = 1'b0;
            phase_d     = 1'b0;
            sof_arm_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vsync_q   <= 1'b0;
            d_href_q    <= 1'b0;
            d_data_q    <= '0;
            pv_vsync_q  <= 1'b0;
            pv_href_q   <= 1'b0;
            state_q     <= ST_SKIP;
            skip_cnt_q  <= '0;
            pixel_cnt_q <= '0;
            line_cnt_q  <= '0;
            px_ovf_q    <= 1'b0;
            ln_ovf_q    <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            sof_arm_q   <= 1'b0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            d_vsync_q   <= bus.i_cam_vsync;
            d_href_q    <= bus.i_cam_href;
            d_data_q    <= bus.i_cam_data;
            pv_vsync_q  <= d_vsync_q;
            pv_href_q   <= d_href_q;
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            pixel_cnt_q <= pixel_cnt_d;
            line_cnt_q  <= line_cnt_d;
            px_ovf_q    <= px_ovf_d;
            ln_ovf_q    <= ln_ovf_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            sof_arm_q   <= sof_arm_d;
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            frame_cnt_q <= frame_cnt_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign bus.o_rgb565 = rgb_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_sof    = sof_q;
    assign bus.o_eol    = eol_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_line   = err_line_q;
    assign o_err_frame  = err_frame_q;
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture with FRAME_SKIP=2, H_ACT=4, V_ACT=2.
module tb_dvp_rgb565_capture;
    localparam int FS = 2;
    localparam int HA = 4;
    localparam int VA = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        err_clr;
    logic [15:0] frame_cnt;
    logic        err_line;
    logic        err_frame;

    dvp_rgb565_capture_if bus();

    dvp_rgb565_capture #(.FRAME_SKIP(FS), .H_ACT(HA), .V_ACT(VA)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .i_capture_en (en),
        .i_err_clr    (err_clr),
        .o_frame_cnt  (frame_cnt),
        .o_err_line   (err_line),
        .o_err_frame  (err_frame)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] px_q[$];
    logic        sof_q[$];
    logic        eol_q[$];

    // Line bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0x00 pair into these pixels.
    logic [15:0] exp_px [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00};

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            px_q.push_back(bus.o_rgb565);
            sof_q.push_back(bus.o_sof);
            eol_q.push_back(bus.o_eol);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        px_q.delete();
        sof_q.delete();
        eol_q.delete();
    endtask

    task automatic count_flags(output int ns, output int ne);
        ns = 0;
        ne = 0;
        foreach (sof_q[k]) if (sof_q[k]) ns++;
        foreach (eol_q[k]) if (eol_q[k]) ne++;
    endtask

    task automatic frame_start();
        bus.i_cam_vsync = 1'b0;
        tick(2);
    endtask

    task automatic send_line(input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.i_cam_href = 1'b1;
            bus.i_cam_data = 8'(32'h12 + i * 34);
            tick(1);
        end
        bus.i_cam_href = 1'b0;
        bus.i_cam_data = 8'h00;
        tick(3);
    endtask

    task automatic frame_end();
        bus.i_cam_vsync = 1'b1;
        tick(4);
    endtask

    task automatic frame(input int nl, input int nb);
        frame_start();
        for (int l = 0; l < nl; l++) send_line(nb);
        frame_end();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    int ns, ne;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        err_clr = 1'b0;
        bus.i_cam_vsync = 1'b1;
        bus.i_cam_href  = 1'b0;
        bus.i_cam_data  = 8'h00;
        tick(3);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_rgb", {16'd0, bus.o_rgb565}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_errs", {30'd0, err_line, err_frame}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Two settling frames, then two captured frames.
        clr_mon();
        frame(2, 8);
        frame(2, 8);
        chk("skip_strobes", px_q.size(), 32'd0);
        chk("skip_fcnt", {16'd0, frame_cnt}, 32'd0);

        clr_mon();
        frame(2, 8);
        chk("f3_strobes", px_q.size(), 32'd8);
        if (px_q.size() == 8) begin
            for (int k = 0; k < 8; k++)
                chk($sformatf("f3_px%0d", k), {16'd0, px_q[k]}, {16'd0, exp_px[k % 4]});
            chk("f3_sof_first", {31'd0, sof_q[0]}, 32'd1);
            chk("f3_eol_3", {31'd0, eol_q[3]}, 32'd1);
            chk("f3_eol_7", {31'd0, eol_q[7]}, 32'd1);
        end
        count_flags(ns, ne);
        chk("f3_sof_cnt", ns, 32'd1);
        chk("f3_eol_cnt", ne, 32'd2);
        chk("f3_fcnt", {16'd0, frame_cnt}, 32'd1);
        chk("f3_errs", {30'd0, err_line, err_frame}, 32'd0);

        clr_mon();
        frame(2, 8);
        chk("f4_strobes", px_q.size(), 32'd8);
        count_flags(ns, ne);
        chk("f4_sof_cnt", ns, 32'd1);
        chk("f4_eol_cnt", ne, 32'd2);
        chk("f4_fcnt", {16'd0, frame_cnt}, 32'd2);
        chk("f4_errs", {30'd0, err_line, err_frame}, 32'd0);

        // Odd-length line.
        clr_mon();
        frame_start();
        send_line(7);
        send_line(8);
        frame_end();
        chk("odd_strobes", px_q.size(), 32'd7);
        count_flags(ns, ne);
        chk("odd_eol_cnt", ne, 32'd1);
        chk("odd_err_line", {31'd0, err_line}, 32'd1);
        chk("odd_err_frame", {31'd0, err_frame}, 32'd0);
        chk("odd_fcnt", {16'd0, frame_cnt}, 32'd3);
        pulse_clr();
        chk("odd_clr", {31'd0, err_line}, 32'd0);

        // Long line: pixels past H_ACT are dropped.
        clr_mon();
        frame_start();
        send_line(12);
        send_line(8);
        frame_end();
        chk("long_strobes", px_q.size(), 32'd8);
        count_flags(ns, ne);
        chk("long_eol_cnt", ne, 32'd2);
        chk("long_err_line", {31'd0, err_line}, 32'd1);
        chk("long_err_frame", {31'd0, err_frame}, 32'd0);
        chk("long_fcnt", {16'd0, frame_cnt}, 32'd4);
        pulse_clr();

        // Too many lines: third line dropped, frame error.
        clr_mon();
        frame(3, 8);
        chk("tall_strobes", px_q.size(), 32'd8);
        chk("tall_err_frame", {31'd0, err_frame}, 32'd1);
        chk("tall_err_line", {31'd0, err_line}, 32'd0);
        chk("tall_fcnt", {16'd0, frame_cnt}, 32'd5);
        pulse_clr();
        chk("tall_clr", {30'd0, err_line, err_frame}, 32'd0);

        // Reset in the middle of a captured line.
        clr_mon();
        frame_start();
        send_line(8);
        for (int i = 0; i < 3; i++) begin
            bus.i_cam_href = 1'b1;
            bus.i_cam_data = 8'(32'h12 + i * 34);
            tick(1);
        end
        rst = 1'b1;
        bus.i_cam_href  = 1'b0;
        bus.i_cam_vsync = 1'b1;
        tick(1);
        chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_rst_rgb", {16'd0, bus.o_rgb565}, 32'd0);
        chk("mid_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("mid_rst_flags", {29'd0, bus.o_sof, bus.o_eol, err_line | err_frame}, 32'd0);
        rst = 1'b0;
        tick(3);
        clr_mon();
        frame(2, 8);
        frame(2, 8);
        chk("rskip_strobes", px_q.size(), 32'd0);
        clr_mon();
        frame(2, 8);
        chk("rcap_strobes", px_q.size(), 32'd8);
        if (px_q.size() > 0) begin
            chk("rcap_px0", {16'd0, px_q[0]}, 32'h1234);
            chk("rcap_sof", {31'd0, sof_q[0]}, 32'd1);
        end
        chk("rcap_fcnt", {16'd0, frame_cnt}, 32'd1);

        // Enable dropped mid-frame: frame finishes, next one is not captured.
        clr_mon();
        frame_start();
        send_line(8);
        en = 1'b0;
        send_line(8);
        frame_end();
        chk("en_off_strobes", px_q.size(), 32'd8);
        chk("en_off_fcnt", {16'd0, frame_cnt}, 32'd2);
        clr_mon();
        frame(2, 8);
        chk("en_off_next_strobes", px_q.size(), 32'd0);
        chk("en_off_next_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Re-enable: capture resumes at the next frame start.
        en = 1'b1;
        clr_mon();
        frame(2, 8);
        chk("en_on_strobes", px_q.size(), 32'd8);
        chk("en_on_fcnt", {16'd0, frame_cnt}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
